// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and types for the MEM pipeline stage.
// Holds the MemToReg writeback-source codes, the MEM-stage FSM states, the
// EX/MEM control bundle and the helpers that classify the access held in M.
package mem_pkg;

  // Writeback source select; 2'b11 is reserved and behaves like MTR_ALU.
  localparam logic [1:0] MTR_MEM = 2'b00;
  localparam logic [1:0] MTR_ALU = 2'b01;
  localparam logic [1:0] MTR_IO  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_t;

  // Control half of the EX/MEM register. The WIDTH-dependent address and
  // store data are kept next to it in the stage so the package stays
  // independent of the data width.
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       mempWrite;
    logic       ioFlag;
    logic [1:0] memToReg;
    logic [3:0] rd;
  } exMemCtrl_t;

  // A data-memory load: writes back, sources memory, not routed to IO.
  function automatic logic isLoad(input exMemCtrl_t c);
    return c.regWrite && (c.memToReg == MTR_MEM) && !c.ioFlag;
  endfunction

  // Any access that needs the variable-latency data-memory port.
  function automatic logic isMemOp(input exMemCtrl_t c);
    return isLoad(c) || (c.memWrite && !c.ioFlag);
  endfunction

  // An IO read returns io_rdata to the register file.
  function automatic logic isIoRead(input exMemCtrl_t c);
    return c.regWrite && c.ioFlag && (c.memToReg == MTR_IO);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion.
// A bubble clears only the write enable; the payload fields hold their last
// value because nothing downstream looks at them while RegWriteW is low.
module mem_wb_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bubble,
  input  logic             regWriteM,
  input  logic [1:0]       memToRegM,
  input  logic [WIDTH-1:0] aluResultM,
  input  logic [3:0]       rdM,
  input  logic             loadM,
  input  logic             ioReadM,
  input  logic [WIDTH-1:0] memRdata,
  input  logic [WIDTH-1:0] ioRdata,
  output logic             RegWriteW,
  output logic [1:0]       MemToRegW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [3:0]       RdW
);

  // Advance the writeback register every edge, or drop a bubble into it.
  // NOTE: non-blocking assignments keep every flop sampling the pre-edge
  // values, so the order of statements in this block cannot change behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      MemToRegW  <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
    end else if (bubble) begin
      RegWriteW  <= 1'b0;
    end else begin
      RegWriteW  <= regWriteM;
      MemToRegW  <= memToRegM;
      ALUResultW <= aluResultM;
      RdW        <= rdM;
      if (loadM) begin
        ReadDataW <= memRdata;
      end else if (ioReadM) begin
        ReadDataW <= ioRdata;
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the hybrid ARM/MIPS pipeline.
// Holds the EX/MEM register, runs the variable-latency data-memory req/ack
// handshake, drives the single-cycle MemP and IO ports, stalls upstream while
// an access is outstanding and feeds the MEM/WB register.
// Optional build macro MEM_TIMEOUT_EN: abandons a data-memory access after
// TIMEOUT wait cycles, writes back a bubble and sets the sticky MemErr flag.
module memory_stage
  import mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemPWriteE,
  input  logic             IOFlagE,
  input  logic [1:0]       MemToRegE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [3:0]       RdE,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             memp_we,
  output logic [WIDTH-1:0] memp_addr,
  output logic [WIDTH-1:0] memp_wdata,
  output logic             io_we,
  output logic [WIDTH-1:0] io_wdata,
  input  logic [WIDTH-1:0] io_rdata,
  output logic             StallM,
  output logic             RegWriteW,
  output logic [1:0]       MemToRegW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [3:0]       RdW
`ifdef MEM_TIMEOUT_EN
  ,
  output logic             MemErr
`endif
);

  exMemCtrl_t       ctrlM;
  logic [WIDTH-1:0] aluResultM;
  logic [WIDTH-1:0] writeDataM;
  memState_t        state;
  memState_t        stateNext;
  logic             memOpM;
  logic             timeoutHit;
  logic             wbBubble;

  // The wait counter is 8 bits wide, so TIMEOUT-1 must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 256) begin : gTimeoutRange
    $error("memory_stage: TIMEOUT must be within 1..256");
  end

  // EX/MEM register: capture the Execute outputs unless an access is stalling.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlM      <= '0;
      aluResultM <= '0;
      writeDataM <= '0;
    end else if (!StallM) begin
      ctrlM.regWrite  <= RegWriteE;
      ctrlM.memWrite  <= MemWriteE;
      ctrlM.mempWrite <= MemPWriteE;
      ctrlM.ioFlag    <= IOFlagE;
      ctrlM.memToReg  <= MemToRegE;
      ctrlM.rd        <= RdE;
      aluResultM      <= ALUResultE;
      writeDataM      <= WriteDataE;
    end
  end

  // Data-memory request straight from the M register; the register holds
  // during WAIT, so address, data and direction stay stable until ack.
  assign memOpM     = isMemOp(ctrlM);
  assign dmem_req   = memOpM && !timeoutHit;
  assign dmem_we    = ctrlM.memWrite;
  assign dmem_addr  = aluResultM;
  assign dmem_wdata = writeDataM;

  // A zero-wait ack completes in the request cycle, so it never stalls.
  assign StallM = dmem_req && !dmem_ack;

  // FSM state register: tracks whether the access in M is already waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state: enter WAIT on an unanswered request, leave on ack or timeout.
  // NOTE: stateNext gets its default before the case so every path assigns it;
  // a path that skipped it would infer a latch.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (dmem_req && !dmem_ack) stateNext = WAIT;
      WAIT: if (dmem_ack || timeoutHit) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] waitCnt;

  // Wait counter: counts cycles spent in WAIT, restarts in IDLE.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      waitCnt <= '0;
    end else begin
      waitCnt <= waitCnt + 8'd1;
    end
  end

  // An ack arriving in the last allowed cycle still completes the access.
  assign timeoutHit = (state == WAIT) && (waitCnt == 8'(TIMEOUT - 1)) && !dmem_ack;

  // Sticky error flag: set by any abandoned access, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      MemErr <= 1'b0;
    end else if (timeoutHit) begin
      MemErr <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // MemP strobe fires only in the first M cycle of an instruction; a
  // following WAIT must not repeat it.
  assign memp_we    = ctrlM.mempWrite && (state == IDLE);
  assign memp_addr  = aluResultM;
  assign memp_wdata = writeDataM;

  // IO accesses complete in one cycle and never use the data-memory port.
  assign io_we    = ctrlM.memWrite && ctrlM.ioFlag;
  assign io_wdata = writeDataM;

  // An abandoned load retires as a bubble, exactly like a stalled cycle.
  assign wbBubble = StallM || timeoutHit;

  mem_wb_reg #(
    .WIDTH(WIDTH)
  ) uMemWb (
    .clk        (clk),
    .reset      (reset),
    .bubble     (wbBubble),
    .regWriteM  (ctrlM.regWrite),
    .memToRegM  (ctrlM.memToReg),
    .aluResultM (aluResultM),
    .rdM        (ctrlM.rd),
    .loadM      (isLoad(ctrlM)),
    .ioReadM    (isIoRead(ctrlM)),
    .memRdata   (dmem_rdata),
    .ioRdata    (io_rdata),
    .RegWriteW  (RegWriteW),
    .MemToRegW  (MemToRegW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW)
  );

endmodule
